mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register. It performs byte/half/word loads and stores against a data memory over a req/ack handshake and freezes upstream stages with Stall while an access is outstanding. It also contains the MEM/WB pipeline register feeding write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: max WAIT cycles before abort; legal 1..255; 0 disables the watchdog.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ALUResultIn  in  32  effective address / ALU result from EX/MEM.
- ReadData2In  in  32  store data.
- PCAddResultIn  in  32  PC+4, passed through for link write-back.
- MemReadIn, MemWriteIn  in  1 each  access type; both high is treated as a write.
- MemSizeIn  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MemUnsignedIn  in  1  zero-extend loads when high.
- MemtoRegIn  in  2  write-back source select, passed through.
- RegWriteIn  in  1  register-file write enable.
- WriteRegIn  in  5  destination register.
- DMemReq  out  1  access request.
- DMemWe  out  1  write strobe.
- DMemAddr  out  32  word address, {ALUResultIn[31:2], 2'b00}.
- DMemByteEn  out  4  byte-lane enables.
- DMemWData  out  32  lane-replicated store data.
- DMemRData  in  32  read word, valid with DMemAck.
- DMemAck  in  1  single-cycle completion pulse.
- Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- ReadDataOut, ALUResultOut, PCAddResultOut  out  32 each  MEM/WB data.
- MemtoRegOut  out  2  MEM/WB write-back source select.
- RegWriteOut  out  1  MEM/WB register-file write enable.
- WriteRegOut  out  5  MEM/WB destination register.
- BusErrOut  out  1  one-cycle pulse on watchdog abort.
- MisalignOut  out  1  one-cycle pulse on misaligned access.

## Operation
- An access is a cycle with MemReadIn or MemWriteIn high that is not suppressed by the misalign check.
- The FSM has two states, IDLE and WAIT.
  - IDLE with an access: next state WAIT.
  - WAIT with DMemAck: next state IDLE.
  - WAIT at watchdog expiry: next state IDLE.
  - DMemAck in IDLE is ignored.
- DMemReq = access & (IDLE | WAIT). DMemReq stays high and all DMem* outputs stay stable until ack or abort.
- Stall = (IDLE & access) | (WAIT & ~DMemAck & ~expiry).
- Store lanes, little-endian (byte at addr[1:0]=0 occupies bits 7:0):
  - Byte: ByteEn = 0001<<addr[1:0], WData = {4{rs2[7:0]}}.
  - Half: ByteEn = 0011<<(2*addr[1]), WData = {2{rs2[15:0]}}.
  - Word: ByteEn = 1111, WData = rs2.
- Loads: ByteEn = 1111.
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Sign-extend unless MemUnsignedIn is high.
- ReadDataOut is the extracted load value for loads, 0 otherwise.
- MEM/WB register loads on every edge where Stall is low. On edges where Stall is high it loads a bubble: RegWriteOut=0, WriteRegOut=0, MemtoRegOut=00, data outputs hold.
- The watchdog counter is 8 bits, cleared on entering WAIT and incremented each WAIT cycle without ack. Expiry occurs when count == TIMEOUT_CYCLES-1 without ack. On expiry:
  - BusErrOut pulses.
  - The instruction retires with RegWriteOut=0.
  - DMemReq drops the next cycle.

## Timing
- Non-memory instruction: 1 cycle, no stall.
- Memory access: 1 + N cycles, where N is the number of cycles until DMemAck. Minimum is 2 cycles (ack on the first WAIT cycle).
- Ack and the MEM/WB update occur on the same edge. Back-to-back accesses re-enter WAIT on the following cycle.
- Reset asserted (low), whether or not an access is mid-flight:
  - State IDLE, counter 0.
  - All registered outputs 0.
  - DMemReq and Stall drop immediately.
- After Reset deasserts: the instruction then in EX/MEM starts a fresh access. A stale ack is ignored.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - Misaligned accesses (half with addr[0]=1, word with addr[1:0]≠0) issue no request and cause no stall.
  - MisalignOut pulses on the MEM/WB edge and RegWriteOut=0.
- MEM_STAGE_MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored (half uses addr[1] only, word ignores addr[1:0]).
  - MisalignOut is tied 0.

## Test plan
- lb from 0x1003, memory word 0x80FF_1234, ack after 1 WAIT cycle -> Stall high 1 cycle; ReadDataOut=0xFFFF_FF80; RegWriteOut=1 on the ack edge.
- sh of rs2=0xABCD to 0x2002 -> DMemByteEn=1100, DMemWData=0xABCD_ABCD, DMemWe=1; after ack RegWriteOut=0.
- lhu from 0x0002 with ack delayed 5 cycles -> DMemReq/DMemAddr stable for 6 cycles; 5 bubbles into MEM/WB; ReadDataOut=upper half zero-extended.
- TIMEOUT_CYCLES=4, no ack -> BusErrOut pulses after 4 WAIT cycles; Stall drops; RegWriteOut=0.
- lw from 0x0006 with the macro defined -> no DMemReq, MisalignOut=1 for 1 cycle; with the macro undefined -> word 0x0004 is loaded.
- Reset pulled low during WAIT -> DMemReq=0 and Stall=0 immediately; all outputs 0; a subsequent stray ack does not load MEM/WB.

Source files
------------

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. Issues byte/half/word data-memory accesses
//               over a req/ack handshake, stalls upstream while waiting, and
//               holds the MEM/WB pipeline register. Optional misalignment trap
//               enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic [31:0] PCAddResultIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemUnsignedIn,
  input  logic [1:0]  MemtoRegIn,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteRegIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemByteEn,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        Stall,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] PCAddResultOut,
  output logic [1:0]  MemtoRegOut,
  output logic        RegWriteOut,
  output logic [4:0]  WriteRegOut,
  output logic        BusErrOut,
  output logic        MisalignOut
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;
  localparam logic       c_WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] c_TIMEOUT_LAST = 8'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [0:0]  r_state;
  logic [0:0]  w_nextState;
  logic [7:0]  r_wdogCount;

  logic        w_isMemOp;
  logic        w_isLoad;
  logic        w_sizeByte;
  logic        w_sizeHalf;
  logic        w_sizeWord;
  logic        w_misalign;
  logic        w_access;
  logic        w_expiry;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadValue;

  assign w_isMemOp  = MemReadIn | MemWriteIn;
  assign w_isLoad   = MemReadIn & ~MemWriteIn;
  assign w_sizeByte = (MemSizeIn == 2'b00);
  assign w_sizeHalf = (MemSizeIn == 2'b01);
  assign w_sizeWord = MemSizeIn[1];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_misalign = w_isMemOp & ((w_sizeHalf & ALUResultIn[0]) |
                                   (w_sizeWord & (|ALUResultIn[1:0])));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = w_isMemOp & ~w_misalign;

  // An ack on the final watchdog cycle wins over the abort.
  assign w_expiry = c_WDOG_EN & (r_state == c_WAIT) & ~DMemAck &
                    (r_wdogCount == c_TIMEOUT_LAST);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (w_access) w_nextState = c_WAIT;
      c_WAIT:  if (DMemAck || w_expiry) w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Handshake outputs; Reset gates them so they drop without waiting for a clock.
  always_comb begin
    DMemReq = 1'b0;
    DMemWe  = 1'b0;
    Stall   = 1'b0;
    if (Reset) begin
      DMemReq = w_access;
      DMemWe  = w_access & MemWriteIn;
      case (r_state)
        c_IDLE:  Stall = w_access;
        c_WAIT:  Stall = ~DMemAck & ~w_expiry;
        default: Stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wdogCount <= 8'd0;
    end else if (r_state == c_IDLE) begin
      r_wdogCount <= 8'd0;
    end else if (!DMemAck) begin
      r_wdogCount <= r_wdogCount + 8'd1;
    end
  end

  assign DMemAddr = {ALUResultIn[31:2], 2'b00};

  always_comb begin
    DMemByteEn = 4'b1111;
    DMemWData  = ReadData2In;
    if (MemWriteIn) begin
      if (w_sizeByte) begin
        DMemByteEn = 4'b0001 << ALUResultIn[1:0];
      end else if (w_sizeHalf) begin
        DMemByteEn = ALUResultIn[1] ? 4'b1100 : 4'b0011;
      end
    end
    if (w_sizeByte) begin
      DMemWData = {4{ReadData2In[7:0]}};
    end else if (w_sizeHalf) begin
      DMemWData = {2{ReadData2In[15:0]}};
    end
  end

  always_comb begin
    case (ALUResultIn[1:0])
      2'd0:    w_loadByte = DMemRData[7:0];
      2'd1:    w_loadByte = DMemRData[15:8];
      2'd2:    w_loadByte = DMemRData[23:16];
      default: w_loadByte = DMemRData[31:24];
    endcase
    w_loadHalf = ALUResultIn[1] ? DMemRData[31:16] : DMemRData[15:0];
    if (w_sizeByte) begin
      w_loadValue = {{24{~MemUnsignedIn & w_loadByte[7]}}, w_loadByte};
    end else if (w_sizeHalf) begin
      w_loadValue = {{16{~MemUnsignedIn & w_loadHalf[15]}}, w_loadHalf};
    end else begin
      w_loadValue = DMemRData;
    end
  end

  // MEM/WB register: a stalled edge inserts a bubble but keeps the data fields.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ReadDataOut    <= 32'd0;
      ALUResultOut   <= 32'd0;
      PCAddResultOut <= 32'd0;
      MemtoRegOut    <= 2'b00;
      RegWriteOut    <= 1'b0;
      WriteRegOut    <= 5'd0;
      BusErrOut      <= 1'b0;
      MisalignOut    <= 1'b0;
    end else if (!Stall) begin
      ReadDataOut    <= (w_isLoad & w_access & ~w_expiry) ? w_loadValue : 32'd0;
      ALUResultOut   <= ALUResultIn;
      PCAddResultOut <= PCAddResultIn;
      MemtoRegOut    <= MemtoRegIn;
      RegWriteOut    <= RegWriteIn & ~w_expiry & ~w_misalign;
      WriteRegOut    <= WriteRegIn;
      BusErrOut      <= w_expiry;
      MisalignOut    <= w_misalign;
    end else begin
      MemtoRegOut    <= 2'b00;
      RegWriteOut    <= 1'b0;
      WriteRegOut    <= 5'd0;
      BusErrOut      <= 1'b0;
      MisalignOut    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Randomized scoreboard bench for mem_stage with a byte-addressed
//               memory model; honours MEM_STAGE_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int T = 6;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResultIn, ReadData2In, PCAddResultIn;
  logic        MemReadIn, MemWriteIn, MemUnsignedIn, RegWriteIn;
  logic [1:0]  MemSizeIn, MemtoRegIn;
  logic [4:0]  WriteRegIn;
  logic        DMemReq, DMemWe, DMemAck, Stall;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemByteEn;
  logic [31:0] ReadDataOut, ALUResultOut, PCAddResultOut;
  logic [1:0]  MemtoRegOut;
  logic        RegWriteOut, BusErrOut, MisalignOut;
  logic [4:0]  WriteRegOut;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset(Reset),
    .ALUResultIn(ALUResultIn), .ReadData2In(ReadData2In), .PCAddResultIn(PCAddResultIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemSizeIn(MemSizeIn),
    .MemUnsignedIn(MemUnsignedIn), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
    .WriteRegIn(WriteRegIn), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemByteEn(DMemByteEn), .DMemWData(DMemWData), .DMemRData(DMemRData),
    .DMemAck(DMemAck), .Stall(Stall), .ReadDataOut(ReadDataOut),
    .ALUResultOut(ALUResultOut), .PCAddResultOut(PCAddResultOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut),
    .BusErrOut(BusErrOut), .MisalignOut(MisalignOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] alu, rs2, pc;
    logic        rd, wr, uns, rw;
    logic [1:0]  size, m2r;
    logic [4:0]  wreg;
    int          d;      // WAIT cycle carrying the ack; 0 = never acked
  } inst_t;

  typedef struct {
    logic [31:0] alu, pc, rdata;
    logic [1:0]  m2r;
    logic        rw, busErr, misal, chkData;
    logic [4:0]  wreg;
  } exp_t;

  exp_t        q[$];
  exp_t        monE;
  logic [7:0]  mem [64];
  int          checks = 0;
  int          errors = 0;
  bit          monActive = 1'b0;
  bit          havePrev = 1'b0;
  bit          prevStallLow = 1'b0;
  logic [31:0] lastAlu, lastPc, lastRd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [5:0] baseOf(input inst_t x);
    logic [5:0] a = x.alu[5:0];
    case (nbytes(x.size))
      1:       return a;
      2:       return {a[5:1], 1'b0};
      default: return {a[5:2], 2'b00};
    endcase
  endfunction

  function automatic bit isMisal(input inst_t x);
    return TRAP && (x.rd || x.wr) &&
           ((x.size == 2'b01 && x.alu[0]) || (x.size[1] && x.alu[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] loadVal(input inst_t x);
    int          n = nbytes(x.size);
    logic [5:0]  b = baseOf(x);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mem[b + 6'(i)]) << (8 * i));
    if (!x.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [5:0] b = {addr[5:2], 2'b00};
    return {mem[b + 6'd3], mem[b + 6'd2], mem[b + 6'd1], mem[b]};
  endfunction

  function automatic logic [3:0] expBe(input inst_t x);
    logic [3:0] be = 4'd0;
    logic [5:0] b  = baseOf(x);
    if (!x.wr) return 4'hF;
    for (int i = 0; i < nbytes(x.size); i++) be[(int'(b[1:0]) + i) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] expWData(input inst_t x);
    logic [31:0] w;
    int          n = nbytes(x.size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = x.rs2[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic storeApply(input inst_t x);
    logic [5:0] b = baseOf(x);
    for (int i = 0; i < nbytes(x.size); i++) mem[b + 6'(i)] = x.rs2[8*i +: 8];
  endtask

  task automatic setInputs(input inst_t x);
    ALUResultIn = x.alu;  ReadData2In = x.rs2;  PCAddResultIn = x.pc;
    MemReadIn = x.rd;     MemWriteIn = x.wr;    MemSizeIn = x.size;
    MemUnsignedIn = x.uns; MemtoRegIn = x.m2r;  RegWriteIn = x.rw;
    WriteRegIn = x.wreg;
  endtask

  function automatic inst_t mk(input bit rd, input bit wr, input logic [1:0] size,
                               input bit uns, input logic [31:0] alu,
                               input logic [31:0] rs2, input int d);
    inst_t x;
    x.rd = rd; x.wr = wr; x.size = size; x.uns = uns; x.alu = alu; x.rs2 = rs2; x.d = d;
    x.pc = $urandom; x.m2r = 2'($urandom); x.wreg = 5'($urandom_range(1, 31));
    x.rw = !wr;
    return x;
  endfunction

  // Issue one instruction, act as the memory, and check the handshake each cycle.
  task automatic doInst(input inst_t x, input bit stray);
    exp_t e;
    bit   misal = isMisal(x);
    bit   acc   = (x.rd || x.wr) && !misal;
    bit   bus   = acc && (x.d == 0 || x.d > T);
    int   endC  = !acc ? 0 : (bus ? T : x.d);
    setInputs(x);
    e.alu = x.alu; e.pc = x.pc; e.m2r = x.m2r; e.wreg = x.wreg;
    e.rw = x.rw && !bus && !misal; e.busErr = bus; e.misal = misal; e.chkData = !bus;
    e.rdata = (acc && x.rd && !x.wr && !bus) ? loadVal(x) : 32'd0;
    q.push_back(e);
    for (int c = 0; c <= endC; c++) begin
      DMemAck   = (acc && !bus && c == x.d) || (c == 0 && stray);
      DMemRData = DMemAck ? memWord(x.alu) : $urandom;
      @(negedge Clk);
      chk("stall", Stall, 32'(acc && c < endC));
      chk("req", DMemReq, 32'(acc));
      if (acc) begin
        chk("addr", DMemAddr, {x.alu[31:2], 2'b00});
        chk("byteen", DMemByteEn, expBe(x));
        chk("we", DMemWe, x.wr);
        if (x.wr) chk("wdata", DMemWData, expWData(x));
      end
      @(posedge Clk); #1;
    end
    DMemAck = 1'b0;
    if (acc && x.wr && !bus) storeApply(x);
  endtask

  // Monitor: an edge with Stall low retires the oldest instruction; otherwise a bubble.
  always @(negedge Clk) begin
    if (monActive && Reset) begin
      if (havePrev) begin
        if (prevStallLow) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL retire: got unexpected retirement alu=%h expected none", ALUResultOut);
          end else begin
            monE = q.pop_front();
            chk("wb_alu", ALUResultOut, monE.alu);
            chk("wb_pc", PCAddResultOut, monE.pc);
            chk("wb_m2r", MemtoRegOut, monE.m2r);
            chk("wb_rw", RegWriteOut, monE.rw);
            chk("wb_wreg", WriteRegOut, monE.wreg);
            chk("wb_buserr", BusErrOut, monE.busErr);
            chk("wb_misalign", MisalignOut, monE.misal);
            if (monE.chkData) chk("wb_rdata", ReadDataOut, monE.rdata);
          end
        end else begin
          chk("bubble_rw", RegWriteOut, 0);
          chk("bubble_wreg", WriteRegOut, 0);
          chk("bubble_m2r", MemtoRegOut, 0);
          chk("bubble_buserr", BusErrOut, 0);
          chk("bubble_misalign", MisalignOut, 0);
          chk("hold_alu", ALUResultOut, lastAlu);
          chk("hold_pc", PCAddResultOut, lastPc);
          chk("hold_rdata", ReadDataOut, lastRd);
        end
      end
      havePrev     = 1'b1;
      prevStallLow = !Stall;
      lastAlu = ALUResultOut; lastPc = PCAddResultOut; lastRd = ReadDataOut;
    end else begin
      havePrev = 1'b0;
    end
  end

  initial begin
    inst_t x;
    int    kind;
    Reset = 1'b0; DMemAck = 1'b0; DMemRData = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    // Access presented during reset must not raise Req or Stall.
    setInputs(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1));
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", DMemReq, 0);     chk("rst_stall", Stall, 0);
    chk("rst_rdata", ReadDataOut, 0); chk("rst_alu", ALUResultOut, 0);
    chk("rst_pc", PCAddResultOut, 0); chk("rst_rw", RegWriteOut, 0);
    chk("rst_wreg", WriteRegOut, 0); chk("rst_m2r", MemtoRegOut, 0);
    chk("rst_buserr", BusErrOut, 0); chk("rst_misalign", MisalignOut, 0);
    Reset = 1'b1;
    monActive = 1'b1;
    @(posedge Clk); #1;

    // Directed cases
    doInst(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h80FF_1234, 1), 1'b0); // sw
    doInst(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 1), 1'b0);         // lb -> FFFFFF80
    doInst(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 1), 1'b0); // sh
    doInst(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0, 5), 1'b0);         // lhu, slow ack
    doInst(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 0), 1'b0);         // watchdog abort
    doInst(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234_5678, 32'd0, 0), 1'b1);         // nop + stray ack
    doInst(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0, 1), 1'b0);         // lw misaligned
    doInst(mk(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, T), 1'b0); // rd+wr = write
    doInst(mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'd0, 2), 1'b1);         // lbu, ack in IDLE

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      x = mk(kind >= 3 && kind <= 6, kind >= 7, 2'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom_range(0, T + 2));
      if (kind >= 7 && $urandom_range(0, 4) == 0) x.rd = 1'b1;
      if (kind < 7) x.rw = 1'($urandom);
      doInst(x, $urandom_range(0, 5) == 0);
    end

    // Reset in the middle of a WAIT, then a stale ack after release.
    x = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0034, 32'd0, 2);
    setInputs(x);
    repeat (2) @(posedge Clk);
    #1;
    monActive = 1'b0;
    Reset = 1'b0;
    #1;
    chk("midrst_req", DMemReq, 0);       chk("midrst_stall", Stall, 0);
    chk("midrst_alu", ALUResultOut, 0);  chk("midrst_rdata", ReadDataOut, 0);
    chk("midrst_pc", PCAddResultOut, 0); chk("midrst_rw", RegWriteOut, 0);
    chk("midrst_wreg", WriteRegOut, 0);  chk("midrst_m2r", MemtoRegOut, 0);
    DMemAck = 1'b1;
    DMemRData = memWord(x.alu);
    @(posedge Clk); #1;
    chk("rstack_alu", ALUResultOut, 0);
    chk("rstack_rw", RegWriteOut, 0);
    Reset = 1'b1;
    monActive = 1'b1;
    doInst(x, 1'b1);
    doInst(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0BAD_F00D, 32'd0, 0), 1'b0);

    @(negedge Clk);
    #1;
    monActive = 1'b0;
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
